// File: rtl/mcu_int_pkg.sv
// -----------------------------------------------------------------------------
// mcu_int_pkg
// Shared definitions for the MCU interrupt controller:
//   - state_t    : controller FSM encoding (IDLE / REQ / SERVICE)
//   - ADDR_*     : config register addresses
//   - N_SRC_MAX  : largest supported source count (bit 15 of EN is GIE)
//   - IDX_W      : width of a source index
// -----------------------------------------------------------------------------
package mcu_int_pkg;

    localparam int N_SRC_MAX = 15;
    localparam int IDX_W     = 4;
    localparam int GIE_BIT   = 15;

    localparam logic [1:0] ADDR_EN   = 2'd0;
    localparam logic [1:0] ADDR_PEND = 2'd1;
    localparam logic [1:0] ADDR_ACT  = 2'd2;
    localparam logic [1:0] ADDR_MODE = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

endpackage

// File: rtl/mcu_int_prio_enc.sv
// -----------------------------------------------------------------------------
// mcu_int_prio_enc
// Combinational fixed-priority encoder, lowest set index wins.
// Ports:
//   mask  in  W      request mask
//   valid out 1      at least one bit of mask is set
//   idx   out IDX_W  index of the lowest set bit (0 when valid=0)
// -----------------------------------------------------------------------------
module mcu_int_prio_enc
    import mcu_int_pkg::*;
#(
    parameter int W = 4
) (
    input  logic [W-1:0]     mask,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);

    // Scan from the top down so the last hit (lowest index) is the result.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        for (int i = W - 1; i >= 0; i--) begin
            if (mask[i]) begin
                valid = 1'b1;
                idx   = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/mcu_int_ctrl.sv
// -----------------------------------------------------------------------------
// mcu_int_ctrl
// Interrupt controller between the MCU interrupt sources and the main
// controller: edge/level detection, pending/enable/mode registers, fixed
// priority (index 0 highest), one request/vector/ack handshake, and tracking
// of the in-service source until return-from-interrupt.
//
// Build option: define INT_NEST_EN to allow a higher-priority source to
// interrupt a running handler (ACT may then hold several bits). Without it,
// no request is raised while a handler is active.
//
// Ports:
//   clk        in   1      system clock
//   rst        in   1      synchronous active-high reset
//   src_in     in   N_SRC  raw source lines; bit 0 is async (2-flop synced)
//   cfg_we     in   1      config write strobe
//   cfg_addr   in   2      register select (0 EN, 1 PEND, 2 ACT, 3 MODE)
//   cfg_wdata  in   16     config write data
//   cfg_rdata  out  16     config read data, combinational from cfg_addr
//   int_req    out  1      interrupt request
//   int_vec    out  8      handler ROM address, valid while int_req=1
//   int_ack    in   1      controller accepted the request (pulse)
//   int_done   in   1      controller executed return-from-interrupt (pulse)
//   int_active out  1      a handler is in service
//   fsm_state  out  2      debug view of the controller FSM
//
// Handshake: int_req rises one cycle after a source becomes eligible, with
// int_vec registered alongside and frozen while int_req=1. The request is
// consumed by an int_ack pulse in any cycle where int_req=1 and the winning
// source is still enabled; int_req is low the following cycle. If the winner
// loses its enable while requesting, int_req drops and a later ack is ignored.
// -----------------------------------------------------------------------------
module mcu_int_ctrl
    import mcu_int_pkg::*;
#(
    parameter int         N_SRC      = 4,     // at most N_SRC_MAX
    parameter logic [7:0] VEC_BASE   = 8'h04,
    parameter logic [7:0] VEC_STRIDE = 8'h04
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SRC-1:0] src_in,
    input  logic             cfg_we,
    input  logic [1:0]       cfg_addr,
    input  logic [15:0]      cfg_wdata,
    output logic [15:0]      cfg_rdata,
    output logic             int_req,
    output logic [7:0]       int_vec,
    input  logic             int_ack,
    input  logic             int_done,
    output logic             int_active,
    output state_t           fsm_state
);

    // Registers
    logic             sync1, sync2;
    logic [N_SRC-1:0] line_prev;
    logic [N_SRC-1:0] en, pend, act, mode;
    logic             gie;
    state_t           state, state_next;
    logic [IDX_W-1:0] idx_q;
    logic [7:0]       vec_q;

    // Combinational
    logic [N_SRC-1:0] line, rise, elig;
    logic [N_SRC-1:0] req_bit, act_low_bit;
    logic [N_SRC-1:0] act_next, pend_next, pend_clr, w1c;
    logic             elig_v, act_v;
    logic [IDX_W-1:0] win_idx, act_idx;
    logic             req_live, ack_take, done_take, nest_req, load_req;
    logic [7:0]       vec_calc;
    logic             cfg_wdata_unused;

    assign cfg_wdata_unused = &{1'b0, cfg_wdata[14:N_SRC]};

    // Only the external pin is asynchronous; the others come from on-chip
    // synchronous logic and are used as-is.
    always_comb begin
        line    = src_in;
        line[0] = sync2;
    end

    assign rise = line & ~line_prev;
    assign elig = pend & en & {N_SRC{gie}};

    mcu_int_prio_enc #(.W(N_SRC)) u_elig_enc (
        .mask  (elig),
        .valid (elig_v),
        .idx   (win_idx)
    );

    mcu_int_prio_enc #(.W(N_SRC)) u_act_enc (
        .mask  (act),
        .valid (act_v),
        .idx   (act_idx)
    );

    assign req_bit     = N_SRC'(1) << idx_q;
    assign act_low_bit = N_SRC'(1) << act_idx;
    assign vec_calc    = VEC_BASE + 8'(win_idx) * VEC_STRIDE;

    // The latched winner stays "live" only while its enable and GIE hold.
    assign req_live  = ((en & req_bit) != '0) && gie;
    assign ack_take  = (state == ST_REQ) && req_live && int_ack;
    assign done_take = int_done && act_v;

    assign act_next = (act | (ack_take ? req_bit : '0))
                    & ~(done_take ? act_low_bit : '0);

    // Edge mode: a new rising edge beats any clear in the same cycle.
    // Level mode: PEND simply follows the line, clears have no effect.
    assign w1c       = (cfg_we && cfg_addr == ADDR_PEND) ? cfg_wdata[N_SRC-1:0] : '0;
    assign pend_clr  = w1c | (ack_take ? req_bit : '0);
    assign pend_next = (mode & line) | (~mode & ((pend & ~pend_clr) | rise));

`ifdef INT_NEST_EN
    assign nest_req = elig_v && act_v && (win_idx < act_idx);
`else
    assign nest_req = 1'b0;
`endif

    always_comb begin
        state_next = state;
        load_req   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (elig_v) begin
                    state_next = ST_REQ;
                    load_req   = 1'b1;
                end
            end
            ST_REQ: begin
                // A withdrawn nested request falls back to the handler
                // that is still running, if any.
                if (!req_live) begin
                    state_next = (act_next != '0) ? ST_SERVICE : ST_IDLE;
                end else if (int_ack) begin
                    state_next = ST_SERVICE;
                end
            end
            ST_SERVICE: begin
                if (nest_req) begin
                    state_next = ST_REQ;
                    load_req   = 1'b1;
                end else if (act_next == '0) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1     <= 1'b0;
            sync2     <= 1'b0;
            line_prev <= '0;
            en        <= '0;
            gie       <= 1'b0;
            pend      <= '0;
            act       <= '0;
            mode      <= '0;
            state     <= ST_IDLE;
            idx_q     <= '0;
            vec_q     <= '0;
        end else begin
            sync1     <= src_in[0];
            sync2     <= sync1;
            line_prev <= line;
            pend      <= pend_next;
            act       <= act_next;
            state     <= state_next;
            if (load_req) begin
                idx_q <= win_idx;
                vec_q <= vec_calc;
            end
            if (cfg_we) begin
                case (cfg_addr)
                    ADDR_EN: begin
                        en  <= cfg_wdata[N_SRC-1:0];
                        gie <= cfg_wdata[GIE_BIT];
                    end
                    ADDR_MODE: mode <= cfg_wdata[N_SRC-1:0];
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        cfg_rdata = '0;
        case (cfg_addr)
            ADDR_EN: begin
                cfg_rdata[N_SRC-1:0] = en;
                cfg_rdata[GIE_BIT]   = gie;
            end
            ADDR_PEND: cfg_rdata[N_SRC-1:0] = pend;
            ADDR_ACT:  cfg_rdata[N_SRC-1:0] = act;
            default:   cfg_rdata[N_SRC-1:0] = mode;
        endcase
    end

    assign int_req    = (state == ST_REQ);
    assign int_vec    = vec_q;
    assign int_active = act_v;
    assign fsm_state  = state;

endmodule
